// File: rtl/id_ex_control_pipe.sv
// ID/EX control pipeline register for the 5-stage MIPS core.
// It decodes the ID-stage instruction into the full control bundle and
// registers it into the ID/EX slot together with the source registers and
// the resolved destination register.
// It also provides the load-use interlock, branch-flush bubbling, a
// syscall-driven halt state and saturating stall/flush statistics.
module id_ex_control_pipe #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             id_valid,
  input  logic             flush,
  input  logic [31:0]      v0,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_op,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic             ex_syscall,
  output logic             ex_signed_ext,
  output logic             ex_reg_dst,
  output logic             ex_beq,
  output logic             ex_bne,
  output logic             ex_jr,
  output logic             ex_jmp,
  output logic             ex_jal,
  output logic             ex_bgez,
  output logic             ex_sv,
  output logic             ex_lbu,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_dst,
  output logic             stall,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W = 5;
  localparam logic [0:0]  S_RUN  = 1'b0;
  localparam logic [0:0]  S_HALT = 1'b1;
  localparam logic [REG_W-1:0] RA_REG = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       syscall;
    logic       signed_ext;
    logic       reg_dst;
    logic       beq;
    logic       bne;
    logic       jr;
    logic       jmp;
    logic       jal;
    logic       bgez;
    logic       sv;
    logic       lbu;
  } ctrl_t;

  logic [5:0]       op;
  logic [5:0]       func;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [4:0]       unused_shamt;

  ctrl_t            dec;
  logic [REG_W-1:0] dec_dst;
  ctrl_t            ex_q;

  logic             reads_rs;
  logic             reads_rt;
  logic             hazard;
  logic             halt_req;
  logic             load_slot;
  logic             take_bubble;

  logic [0:0]       state;
  logic [0:0]       state_next;

  assign op           = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign func         = instr[5:0];
  assign unused_shamt = instr[10:6];

  // Instruction decode into the control bundle.
  always_comb begin
    dec = '0;
    case (op)
      6'd0: begin
        case (func)
          6'd0:  begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd0; end
          6'd2:  begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd2; end
          6'd3:  begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd1; end
          6'd6:  begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.sv = 1'b1; dec.alu_op = 4'd2; end
          6'd7:  begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.sv = 1'b1; dec.alu_op = 4'd1; end
          6'd32: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd5; end
          6'd33: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd5; end
          6'd34: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd6; end
          6'd36: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd7; end
          6'd37: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd8; end
          6'd39: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd10; end
          6'd42: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd11; end
          6'd43: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_op = 4'd12; end
          6'd8:  begin dec.jr = 1'b1; dec.jmp = 1'b1; end
          6'd12: begin dec.syscall = 1'b1; end
          default: dec = '0;
        endcase
      end
      6'd8, 6'd9: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.signed_ext = 1'b1; dec.alu_op = 4'd5;
      end
      6'd10: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.signed_ext = 1'b1; dec.alu_op = 4'd11;
      end
      6'd12: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 4'd7;
      end
      6'd13: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 4'd8;
      end
      6'd35: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1;
        dec.signed_ext = 1'b1; dec.alu_op = 4'd5;
      end
      6'd36: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1;
        dec.signed_ext = 1'b1; dec.lbu = 1'b1; dec.alu_op = 4'd5;
      end
      6'd43: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.signed_ext = 1'b1; dec.alu_op = 4'd5;
      end
      6'd4:  dec.beq = 1'b1;
      6'd5:  dec.bne = 1'b1;
      6'd1:  begin dec.bgez = 1'b1; dec.signed_ext = 1'b1; dec.alu_op = 4'd11; end
      6'd2:  dec.jmp = 1'b1;
      6'd3:  begin dec.jmp = 1'b1; dec.jal = 1'b1; dec.reg_write = 1'b1; end
      6'd40: dec.signed_ext = 1'b1;
      default: dec = '0;
    endcase
  end

  // Destination register selection: jal links to $ra, R-type writes rd.
  always_comb begin
    dec_dst = rt;
    if (dec.jal) begin
      dec_dst = RA_REG;
    end else if (dec.reg_dst) begin
      dec_dst = rd;
    end
  end

  // Which source registers the ID instruction actually reads.
  always_comb begin
    reads_rs = 1'b1;
    if ((op == 6'd2) || (op == 6'd3)) begin
      reads_rs = 1'b0;
    end
    if ((op == 6'd0) &&
        ((func == 6'd0) || (func == 6'd2) || (func == 6'd3) || (func == 6'd12))) begin
      reads_rs = 1'b0;
    end
    reads_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
  end

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    hazard = ex_valid && ex_q.mem_to_reg && (ex_dst != '0) && id_valid &&
             ((reads_rs && (rs == ex_dst)) || (reads_rt && (rt == ex_dst)));
  end

  // Halt request when a syscall in EX carries the halt code.
  always_comb begin
    halt_req = (state == S_RUN) && ex_valid && ex_q.syscall && (v0 == HALT_CODE);
  end

  // Next-state logic plus stall and slot-update controls.
  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    load_slot   = 1'b0;
    take_bubble = 1'b0;
    case (state)
      S_RUN: begin
        stall = hazard && !flush;
        if (halt_req) begin
          state_next = S_HALT;
        end else begin
          load_slot   = 1'b1;
          take_bubble = flush || stall || !id_valid;
        end
      end
      S_HALT: begin
        stall = 1'b1;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  // FSM state and registered halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      halt  <= 1'b0;
    end else begin
      state <= state_next;
      halt  <= (state_next == S_HALT);
    end
  end

  // ID/EX pipeline register; a bubble clears every field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_dst   <= '0;
    end else if (load_slot) begin
      if (take_bubble) begin
        ex_valid <= 1'b0;
        ex_q     <= '0;
        ex_rs    <= '0;
        ex_rt    <= '0;
        ex_dst   <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_q     <= dec;
        ex_rs    <= rs;
        ex_rt    <= rt;
        ex_dst   <= dec_dst;
      end
    end
  end

  // Saturating stall and flush statistics, counted only while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == S_RUN) begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_alu_op     = ex_q.alu_op;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_syscall    = ex_q.syscall;
  assign ex_signed_ext = ex_q.signed_ext;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_beq        = ex_q.beq;
  assign ex_bne        = ex_q.bne;
  assign ex_jr         = ex_q.jr;
  assign ex_jmp        = ex_q.jmp;
  assign ex_jal        = ex_q.jal;
  assign ex_bgez       = ex_q.bgez;
  assign ex_sv         = ex_q.sv;
  assign ex_lbu        = ex_q.lbu;

endmodule

// File: tb/tb_id_ex_control_pipe.sv
// Self-checking bench for id_ex_control_pipe: decode table, directed
// interlock/flush/halt/reset sequences and a randomized stream checked
// against a transaction-level reference model.
module tb_id_ex_control_pipe;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          id_valid;
  logic          flush;
  logic [31:0]   v0;
  logic          ex_valid;
  logic [3:0]    ex_alu_op;
  logic          ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_syscall;
  logic          ex_signed_ext, ex_reg_dst, ex_beq, ex_bne, ex_jr, ex_jmp, ex_jal;
  logic          ex_bgez, ex_sv, ex_lbu;
  logic [4:0]    ex_rs, ex_rt, ex_dst;
  logic          stall, halt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_control_pipe #(.CNT_W(CW), .HALT_CODE(32'd10)) dut (
    .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid), .flush(flush), .v0(v0),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_syscall(ex_syscall), .ex_signed_ext(ex_signed_ext), .ex_reg_dst(ex_reg_dst),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_jr(ex_jr), .ex_jmp(ex_jmp), .ex_jal(ex_jal),
    .ex_bgez(ex_bgez), .ex_sv(ex_sv), .ex_lbu(ex_lbu), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .stall(stall), .halt(halt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: contents of the EX slot plus halt flag and counters.
  logic        m_valid;
  logic [3:0]  m_alu;
  logic [14:0] m_bits;   // m2r mw src rw sys sext rdst beq bne jr jmp jal bgez sv lbu
  logic [4:0]  m_rs, m_rt, m_dst;
  logic        m_halt;
  int          m_sc, m_fc;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  alu;
    logic [14:0] bits;
    logic [4:0]  dst;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input int f);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
  endfunction

  function automatic logic [31:0] i_ins(input int o, input int s, input int t, input int imm);
    return {6'(o), 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input int a, input logic [14:0] b, input int d);
    vec_t v;
    v.ins = i; v.alu = 4'(a); v.bits = b; v.dst = 5'(d);
    return v;
  endfunction

  // Decode by membership in the mnemonic sets of the instruction tables.
  function automatic void ref_decode(input logic [31:0] i, output logic [3:0] alu,
                                     output logic [14:0] b, output logic [4:0] d);
    int  o, f;
    logic rtype_alu;
    o = int'(i[31:26]);
    f = int'(i[5:0]);
    rtype_alu = (o == 0) && (f inside {0, 2, 3, 6, 7, 32, 33, 34, 36, 37, 39, 42, 43});
    b[14] = o inside {35, 36};
    b[13] = (o == 43);
    b[12] = o inside {8, 9, 10, 12, 13, 35, 36, 43};
    b[11] = (o inside {3, 8, 9, 10, 12, 13, 35, 36}) || rtype_alu;
    b[10] = (o == 0) && (f == 12);
    b[9]  = o inside {1, 8, 9, 10, 35, 36, 40, 43};
    b[8]  = rtype_alu;
    b[7]  = (o == 4);
    b[6]  = (o == 5);
    b[5]  = (o == 0) && (f == 8);
    b[4]  = ((o == 0) && (f == 8)) || (o inside {2, 3});
    b[3]  = (o == 3);
    b[2]  = (o == 1);
    b[1]  = (o == 0) && (f inside {6, 7});
    b[0]  = (o == 36);
    alu = 4'd0;
    if (o == 0) begin
      if (f inside {3, 7})        alu = 4'd1;
      else if (f inside {2, 6})   alu = 4'd2;
      else if (f inside {32, 33}) alu = 4'd5;
      else if (f == 34)           alu = 4'd6;
      else if (f == 36)           alu = 4'd7;
      else if (f == 37)           alu = 4'd8;
      else if (f == 39)           alu = 4'd10;
      else if (f == 42)           alu = 4'd11;
      else if (f == 43)           alu = 4'd12;
    end else begin
      if (o inside {8, 9, 35, 36, 43}) alu = 4'd5;
      else if (o == 12)                alu = 4'd7;
      else if (o == 13)                alu = 4'd8;
      else if (o inside {1, 10})       alu = 4'd11;
    end
    if (b[3])      d = 5'd31;
    else if (b[8]) d = i[15:11];
    else           d = i[20:16];
  endfunction

  function automatic logic exp_stall();
    int  o, f;
    logic rrs, rrt;
    if (m_halt) return 1'b1;
    o = int'(instr[31:26]);
    f = int'(instr[5:0]);
    rrs = !(o inside {2, 3}) && !((o == 0) && (f inside {0, 2, 3, 12}));
    rrt = (o == 0) || (o inside {4, 5, 43});
    return !flush && m_valid && m_bits[14] && (m_dst != 5'd0) && id_valid &&
           ((rrs && (instr[25:21] == m_dst)) || (rrt && (instr[20:16] == m_dst)));
  endfunction

  function automatic logic [44:0] model_pack();
    return {m_valid, m_alu, m_bits, m_rs, m_rt, m_dst, exp_stall(), m_halt,
            4'(m_sc), 4'(m_fc)};
  endfunction

  function automatic logic [14:0] dut_bits();
    return {ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_syscall,
            ex_signed_ext, ex_reg_dst, ex_beq, ex_bne, ex_jr, ex_jmp, ex_jal,
            ex_bgez, ex_sv, ex_lbu};
  endfunction

  function automatic logic [44:0] dut_pack();
    return {ex_valid, ex_alu_op, dut_bits(), ex_rs, ex_rt, ex_dst, stall, halt,
            stall_cnt, flush_cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_alu = '0; m_bits = '0; m_rs = '0; m_rt = '0; m_dst = '0;
    m_halt = 1'b0; m_sc = 0; m_fc = 0;
  endtask

  // What one clock edge does to the model, given the current inputs.
  task automatic model_edge();
    logic s;
    if (!m_halt) begin
      s = exp_stall();
      if (s && m_sc < CMAX) m_sc++;
      if (flush && m_fc < CMAX) m_fc++;
      if (m_valid && m_bits[10] && v0 == 32'd10) begin
        m_halt = 1'b1;
      end else if (flush || s || !id_valid) begin
        m_valid = 1'b0; m_alu = '0; m_bits = '0; m_rs = '0; m_rt = '0; m_dst = '0;
      end else begin
        ref_decode(instr, m_alu, m_bits, m_dst);
        m_valid = 1'b1;
        m_rs = instr[25:21];
        m_rt = instr[20:16];
      end
    end
  endtask

  task automatic step(input logic [31:0] i, input logic v, input logic f, input logic [31:0] vv);
    instr = i; id_valid = v; flush = f; v0 = vv;
    #2;
    chk("cycle", 64'(dut_pack()), 64'(model_pack()));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle and check the outputs clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("reset_async", 64'(dut_pack()), 64'(model_pack()));
    chk("reset_halt", 64'(halt), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_step(input logic [31:0] vv);
    logic [31:0] i;
    int s, t, d;
    s = $urandom_range(0, 3); t = $urandom_range(0, 3); d = $urandom_range(0, 3);
    case ($urandom_range(0, 12))
      0, 1: i = i_ins(35, s, t, 0);
      2:    i = i_ins(36, s, t, 4);
      3:    i = r_ins(s, t, d, 32);
      4:    i = r_ins(s, t, d, 34);
      5:    i = r_ins(s, t, d, 0);
      6:    i = i_ins(43, s, t, 8);
      7:    i = i_ins(4, s, t, 2);
      8:    i = {6'd2, 26'($urandom)};
      9:    i = {6'd3, 26'($urandom)};
      10:   i = r_ins(0, 0, 0, 12);
      11:   i = i_ins(8, s, t, 5);
      default: i = r_ins(s, 0, 0, 8);
    endcase
    step(i, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15), vv);
  endtask

  logic [31:0] lw8, add98, jmp_i, lw0, add900, addi2, sysc;
  logic [44:0] frozen;

  initial begin
    rst = 1'b0; instr = '0; id_valid = 1'b0; flush = 1'b0; v0 = '0;
    model_reset();
    lw8   = i_ins(35, 0, 8, 0);
    add98 = r_ins(8, 8, 9, 32);
    jmp_i = {6'd2, 26'd64};
    lw0   = i_ins(35, 0, 0, 0);
    add900 = r_ins(0, 0, 9, 32);
    addi2 = i_ins(8, 0, 2, 10);
    sysc  = r_ins(0, 0, 0, 12);

    // Decode table, rs=1 rt=2 rd=3.
    tbl.push_back(mk(r_ins(1, 2, 3, 0),  0,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 2),  2,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 3),  1,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 6),  2,  15'b000100100000010, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 7),  1,  15'b000100100000010, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 32), 5,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 33), 5,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 34), 6,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 36), 7,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 37), 8,  15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 39), 10, 15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 42), 11, 15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 43), 12, 15'b000100100000000, 3));
    tbl.push_back(mk(r_ins(1, 2, 3, 8),  0,  15'b000000000110000, 2));
    tbl.push_back(mk(r_ins(1, 2, 3, 12), 0,  15'b000010000000000, 2));
    tbl.push_back(mk(r_ins(1, 2, 3, 1),  0,  15'b000000000000000, 2));
    tbl.push_back(mk(i_ins(8, 1, 2, 0),  5,  15'b001101000000000, 2));
    tbl.push_back(mk(i_ins(9, 1, 2, 0),  5,  15'b001101000000000, 2));
    tbl.push_back(mk(i_ins(10, 1, 2, 0), 11, 15'b001101000000000, 2));
    tbl.push_back(mk(i_ins(12, 1, 2, 0), 7,  15'b001100000000000, 2));
    tbl.push_back(mk(i_ins(13, 1, 2, 0), 8,  15'b001100000000000, 2));
    tbl.push_back(mk(i_ins(35, 1, 2, 0), 5,  15'b101101000000000, 2));
    tbl.push_back(mk(i_ins(36, 1, 2, 0), 5,  15'b101101000000001, 2));
    tbl.push_back(mk(i_ins(43, 1, 2, 0), 5,  15'b011001000000000, 2));
    tbl.push_back(mk(i_ins(4, 1, 2, 0),  0,  15'b000000010000000, 2));
    tbl.push_back(mk(i_ins(5, 1, 2, 0),  0,  15'b000000001000000, 2));
    tbl.push_back(mk(i_ins(1, 1, 2, 0),  11, 15'b000001000000100, 2));
    tbl.push_back(mk(i_ins(2, 1, 2, 0),  0,  15'b000000000010000, 2));
    tbl.push_back(mk(i_ins(3, 1, 2, 0),  0,  15'b000100000011000, 31));
    tbl.push_back(mk(i_ins(40, 1, 2, 0), 0,  15'b000001000000000, 2));
    tbl.push_back(mk(i_ins(63, 1, 2, 0), 0,  15'b000000000000000, 2));

    do_reset();

    foreach (tbl[k]) begin
      step(tbl[k].ins, 1'b1, 1'b0, 32'd0);
      chk($sformatf("decode_%0d", k), 64'({ex_valid, ex_alu_op, dut_bits(), ex_dst}),
          64'({1'b1, tbl[k].alu, tbl[k].bits, tbl[k].dst}));
      step(32'd0, 1'b0, 1'b0, 32'd0);
    end

    // Load-use: one stall cycle, one bubble, add arrives a cycle late.
    do_reset();
    step(lw8, 1'b1, 1'b0, 32'd0);
    instr = add98; id_valid = 1'b1; flush = 1'b0; #1;
    chk("lu_stall_first", 64'(stall), 64'(1));
    step(add98, 1'b1, 1'b0, 32'd0);
    chk("lu_bubble", 64'(ex_valid), 64'(0));
    #1;
    chk("lu_stall_second", 64'(stall), 64'(0));
    step(add98, 1'b1, 1'b0, 32'd0);
    chk("lu_add_in_ex", 64'({ex_valid, ex_alu_op, ex_dst}), 64'({1'b1, 4'd5, 5'd9}));
    chk("lu_stall_cnt", 64'(stall_cnt), 64'(1));
    step(32'd0, 1'b0, 1'b0, 32'd0);

    // No stall for a jump after a load, nor for a load into $0.
    do_reset();
    step(lw8, 1'b1, 1'b0, 32'd0);
    instr = jmp_i; id_valid = 1'b1; #1;
    chk("lw_j_nostall", 64'(stall), 64'(0));
    step(jmp_i, 1'b1, 1'b0, 32'd0);
    step(lw0, 1'b1, 1'b0, 32'd0);
    instr = add900; id_valid = 1'b1; #1;
    chk("lw0_nostall", 64'(stall), 64'(0));
    step(add900, 1'b1, 1'b0, 32'd0);
    chk("lw0_add_in_ex", 64'({ex_valid, ex_dst}), 64'({1'b1, 5'd9}));

    // Flush overrides stall.
    do_reset();
    step(lw8, 1'b1, 1'b0, 32'd0);
    instr = add98; id_valid = 1'b1; flush = 1'b1; #1;
    chk("sf_stall", 64'(stall), 64'(0));
    step(add98, 1'b1, 1'b1, 32'd0);
    chk("sf_bubble", 64'(ex_valid), 64'(0));
    chk("sf_counts", 64'({stall_cnt, flush_cnt}), 64'({4'd0, 4'd1}));

    // Halting syscall.
    do_reset();
    step(addi2, 1'b1, 1'b0, 32'd10);
    step(sysc, 1'b1, 1'b0, 32'd10);
    chk("pre_halt", 64'(halt), 64'(0));
    step(r_ins(1, 1, 1, 32), 1'b1, 1'b0, 32'd10);
    chk("halt_set", 64'(halt), 64'(1));
    chk("halt_sys_held", 64'({ex_valid, ex_syscall}), 64'(2'b11));
    frozen = dut_pack();
    for (int c = 0; c < 20; c++) rand_step(32'd10);
    chk("halt_frozen", 64'(dut_pack()), 64'({frozen[44:10], 1'b1, 1'b1, frozen[7:0]}));
    do_reset();

    // Syscall with a non-halt code passes through.
    step(addi2, 1'b1, 1'b0, 32'd1);
    step(sysc, 1'b1, 1'b0, 32'd1);
    step(r_ins(1, 2, 3, 32), 1'b1, 1'b0, 32'd1);
    chk("nohalt", 64'({halt, ex_valid, ex_dst}), 64'({1'b0, 1'b1, 5'd3}));

    // Reset mid-stream.
    for (int c = 0; c < 6; c++) step(i_ins(35, 1, c + 1, 0), 1'b1, 1'b0, 32'd0);
    do_reset();
    chk("rst_mid_valid", 64'({ex_valid, ex_dst, stall_cnt}), 64'(0));

    // Randomized stream against the model (counters saturate at CW bits).
    for (int c = 0; c < 600; c++) rand_step(32'($urandom_range(0, 9)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
